// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file with two write ports, a per-entry busy
// scoreboard and a sequential whole-array clear engine.
//
// Ports:
//   clk       - sole clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   rd_addr   - NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   - NRD packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy   - per read port: addressed register has a pending reservation
//   wr0_*     - write port 0 (enable, address, data)
//   wr1_*     - write port 1 (enable, address, data); wins over port 0
//   rsv_en    - mark register rsv_addr busy
//   rsv_addr  - reservation address
//   clr_req   - start a sequential clear of every entry and busy bit
//   ready     - high when idle, low while the clear is running
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;
  logic upd;

  // Entry 0 is hard-wired to zero when ZERO_R0 is set.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // Writes and reservations only act in IDLE, and the edge that accepts
  // clr_req drops them so the clear starts from a consistent snapshot.
  assign upd    = (state == IDLE) && !clr_req;
  assign wr0_ok = wr0_en && !is_zero_reg(wr0_addr);
  assign wr1_ok = wr1_en && !is_zero_reg(wr1_addr);
  assign rsv_ok = rsv_en && !is_zero_reg(rsv_addr);

  assign ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: the clear leaves on the same edge that wipes the
  // last entry, so it lasts exactly DEPTH cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear counter: parked at 0 outside CLEAR, never runs past LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Storage array. wr1 is written second so it wins on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (upd) begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard. The reservation is applied last so a same-cycle
  // reserve+write to one address leaves the entry busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (state == CLEAR) begin
      busy[cnt] <= 1'b0;
    end else if (upd) begin
      if (wr0_ok) busy[wr0_addr] <= 1'b0;
      if (wr1_ok) busy[wr1_addr] <= 1'b0;
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

  // Combinational read ports. Bypass only exists in IDLE; during CLEAR
  // the stored contents are returned as-is. Outputs are forced to zero
  // while reset is held so a live write bus cannot leak through bypass.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic              bsy;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    val     = '0;
    bsy     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rd_addr[i*ADDR_W +: ADDR_W];
      val = mem[ra];
      bsy = busy[ra];
      if (state == IDLE) begin
        if (wr1_ok && (wr1_addr == ra)) begin
          val = wr1_data;
        end else if (wr0_ok && (wr0_addr == ra)) begin
          val = wr0_data;
        end
        if ((wr1_ok && (wr1_addr == ra)) || (wr0_ok && (wr0_addr == ra))) begin
          bsy = 1'b0;
        end
      end
      if (is_zero_reg(ra) || !rst_n) begin
        val = '0;
        bsy = 1'b0;
      end
      rd_data[i*DATA_W +: DATA_W] = val;
      rd_busy[i]                  = bsy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed, table-driven bench for regfile_mp with default parameters
// (32-bit data, 32 entries, two read ports, entry 0 hard-wired to zero).
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en;
  logic [4:0]  wr0_addr;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_addr;
  logic [31:0] wr1_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        clr_req;
  logic        ready;

  int passed;
  int total;

  regfile_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NRD    (2),
    .ZERO_R0(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr0_en  (wr0_en),
    .wr0_addr(wr0_addr),
    .wr0_data(wr0_data),
    .wr1_en  (wr1_en),
    .wr1_addr(wr1_addr),
    .wr1_data(wr1_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .clr_req (clr_req),
    .ready   (ready)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w0e;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    logic        w1e;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    logic        rse;
    logic [4:0]  rsa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    clr_req = 1'b0;
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector, check the combinational outputs mid-cycle, then clock.
  task automatic applyStimulus(input vec_t v, input int idx);
    wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
    wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
    rsv_en = v.rse; rsv_addr = v.rsa;
    clr_req = 1'b0;
    rd_addr = {v.ra1, v.ra0};
    #1;
    checkOutput($sformatf("vec%0d rd_data0", idx), rd_data[31:0], v.ed0);
    checkOutput($sformatf("vec%0d rd_data1", idx), rd_data[63:32], v.ed1);
    checkOutput($sformatf("vec%0d rd_busy0", idx), {31'b0, rd_busy[0]}, {31'b0, v.eb0});
    checkOutput($sformatf("vec%0d rd_busy1", idx), {31'b0, rd_busy[1]}, {31'b0, v.eb1});
    checkOutput($sformatf("vec%0d ready", idx), {31'b0, ready}, 32'd1);
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;

    //         w0e  w0a   w0d            w1e  w1a   w1d            rse  rsa   ra0   ra1   ed0            ed1            eb0   eb1
    vecs[0]  = '{1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h5555FFFF, 1'b0, 5'd0, 5'd5, 5'd0, 32'h5555FFFF, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd3, 32'h5555FFFF, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd5, 32'h0,        32'h5555FFFF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h00000077, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd7, 5'd9, 32'h00000077, 32'h00000099, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h00000099, 32'h00000077, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h00000999, 1'b0, 5'd0, 5'd9, 5'd9, 32'h00000999, 32'h00000999, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5, 32'h00000999, 32'h5555FFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd3, 32'h00000033, 1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0, 5'd3, 5'd4, 32'h00000033, 32'h00000044, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 32'h00000033, 32'h00000044, 1'b0, 1'b0};

    // Reset state, checked while reset is held and a write is on the bus.
    idleInputs();
    rst_n   = 1'b0;
    rd_addr = {5'd5, 5'd5};
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h12345678;
    #2;
    checkOutput("reset ready", {31'b0, ready}, 32'd1);
    checkOutput("reset rd_data0", rd_data[31:0], 32'h0);
    checkOutput("reset rd_busy", {30'b0, rd_busy}, 32'h0);
    tick();
    tick();
    idleInputs();
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset entry5", rd_data[31:0], 32'h0);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
    end
    idleInputs();

    // Preload entries 1..31 with their index; reserve 12 late in the run.
    for (int k = 1; k < 32; k++) begin
      wr0_en   = 1'b1;
      wr0_addr = 5'(k);
      wr0_data = 32'(k);
      rsv_en   = (k == 20);
      rsv_addr = 5'd12;
      tick();
    end
    idleInputs();
    rd_addr = {5'd31, 5'd12};
    #1;
    checkOutput("preload entry12", rd_data[31:0], 32'd12);
    checkOutput("preload busy12", {31'b0, rd_busy[0]}, 32'd1);
    checkOutput("preload entry31", rd_data[63:32], 32'd31);

    // Clear request edge: same-cycle write and reservation are dropped.
    clr_req = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h00000BAD;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idleInputs();

    // Clear walk: entry k still holds its value before edge k+1,
    // entry k-1 already reads zero, and mid-clear traffic is ignored.
    for (int k = 0; k < 32; k++) begin
      clr_req = (k == 15);
      wr0_en = (k == 10); wr0_addr = 5'd20; wr0_data = 32'h0000F00D;
      wr1_en = (k == 10); wr1_addr = 5'd21; wr1_data = 32'h0000BEEF;
      rsv_en = (k == 10); rsv_addr = 5'd22;
      rd_addr = {((k == 10) ? 5'd20 : 5'(k - 1)), 5'(k)};
      #1;
      checkOutput($sformatf("clear k%0d ready", k), {31'b0, ready}, 32'd0);
      checkOutput($sformatf("clear k%0d entry", k), rd_data[31:0], 32'(k));
      checkOutput($sformatf("clear k%0d busy", k), {31'b0, rd_busy[0]}, {31'b0, (k == 12)});
      if (k == 10) begin
        checkOutput("clear no-bypass entry20", rd_data[63:32], 32'd20);
      end else if (k > 0) begin
        checkOutput($sformatf("clear k%0d prev", k), rd_data[63:32], 32'h0);
      end
      tick();
    end
    idleInputs();
    #1;
    checkOutput("clear done ready", {31'b0, ready}, 32'd1);

    // Every entry and busy bit zero after the clear (writes at 20/21 lost).
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd22, 5'(a)};
      #1;
      checkOutput($sformatf("after clear entry%0d", a), rd_data[31:0], 32'h0);
      checkOutput($sformatf("after clear busy%0d", a), {31'b0, rd_busy[0]}, 32'h0);
    end
    checkOutput("after clear busy22", {31'b0, rd_busy[1]}, 32'h0);
    tick();

    // Asynchronous reset in the middle of a clear.
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h00000066;
    tick();
    idleInputs();
    clr_req = 1'b1;
    tick();
    idleInputs();
    tick();
    tick();
    rd_addr = {5'd0, 5'd6};
    #1;
    checkOutput("mid-clear ready", {31'b0, ready}, 32'd0);
    checkOutput("mid-clear entry6", rd_data[31:0], 32'h00000066);
    #1;
    rst_n  = 1'b0;
    wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 32'h00000123;
    #1;
    checkOutput("async reset ready", {31'b0, ready}, 32'd1);
    checkOutput("async reset entry6", rd_data[31:0], 32'h0);
    checkOutput("async reset busy", {30'b0, rd_busy}, 32'h0);
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("after reset ready", {31'b0, ready}, 32'd1);
    checkOutput("after reset entry6", rd_data[31:0], 32'h0);
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h00000042;
    tick();
    idleInputs();
    #1;
    checkOutput("after reset write6", rd_data[31:0], 32'h00000042);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL expose parameters, one per line (name, default, meaning):
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries.
- NRD, 2, number of read ports (1..4).
- ZERO_R0, 1, when 1 entry 0 reads as zero and ignores writes and reservations.
REQ-002 The module SHALL expose ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- rd_addr, in, NRD*ADDR_W, read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data, out, NRD*DATA_W, read data, packed the same way.
- rd_busy, out, NRD, per-port "register has a pending reservation".
- wr0_en, in, 1, write port 0 enable.
- wr0_addr, in, ADDR_W, write port 0 address.
- wr0_data, in, DATA_W, write port 0 data.
- wr1_en, in, 1, write port 1 enable.
- wr1_addr, in, ADDR_W, write port 1 address.
- wr1_data, in, DATA_W, write port 1 data.
- rsv_en, in, 1, reserve (mark busy) register rsv_addr.
- rsv_addr, in, ADDR_W, reservation address.
- clr_req, in, 1, request a sequential clear of the whole array.
- ready, out, 1, high in IDLE; low while clearing.

Function
REQ-003 Reads SHALL be combinational, with no cycle of latency.
REQ-004 Read bypass in IDLE SHALL follow this priority:
- ZERO_R0 and address 0 -> 0;
- else wr1_en with matching address -> wr1_data;
- else wr0_en with matching address -> wr0_data;
- else the stored value.
REQ-005 Writes SHALL commit at the rising edge. When both ports target the same address, wr1 SHALL win.
REQ-006 A scoreboard SHALL hold one busy bit per entry.
REQ-007 rsv_en SHALL set busy[rsv_addr]. A committed write on either port SHALL clear busy for its address.
REQ-008 A reservation and a write to the same address in the same cycle SHALL leave busy set; the new reservation wins.
REQ-009 rd_busy[i] SHALL equal busy[rd_addr[i]] AND NOT (a same-cycle write to that address). rd_busy[i] SHALL be 0 for address 0 when ZERO_R0=1.
REQ-010 When ZERO_R0=1, writes and reservations to address 0 SHALL be ignored.
REQ-011 The FSM SHALL have two states, IDLE and CLEAR.
REQ-012 IDLE -> CLEAR SHALL occur on clr_req=1 at a clock edge while in IDLE. That edge SHALL ignore any same-cycle writes and reservations.
REQ-013 In CLEAR, an ADDR_W-bit counter SHALL start at 0. Each cycle it SHALL zero the entry and busy bit at the counter address, then increment.
REQ-014 When the counter reaches DEPTH-1, CLEAR SHALL zero that entry and return to IDLE on the same edge. The clear therefore takes exactly DEPTH cycles, and ready is high on the following cycle.
REQ-015 In CLEAR:
- writes, reservations and clr_req SHALL be ignored;
- reads SHALL return stored contents with no bypass;
- rd_busy SHALL reflect stored busy bits.
REQ-016 The counter SHALL NOT wrap beyond DEPTH-1. Address arithmetic SHALL be unsigned, modulo 2^ADDR_W.

Reset
REQ-017 While rst_n=0, regardless of clk:
- all entries SHALL be 0;
- all busy bits SHALL be 0;
- the FSM SHALL be in IDLE with the counter at 0;
- ready SHALL be 1;
- rd_data SHALL be 0;
- rd_busy SHALL be 0.
REQ-018 Reset asserted mid-CLEAR SHALL abort the clear and apply REQ-017. Reset deassertion SHALL take effect at the next rising edge.

Verification
REQ-019 Bypass and priority: wr0 (addr 5, 0xAAAA0000) and wr1 (addr 5, 0x5555FFFF) in the same cycle, rd_addr[0]=5 -> rd_data[0]=0x5555FFFF that cycle and after the edge.
REQ-020 Zero register: write 0xDEADBEEF to addr 0 and reserve addr 0 -> reads of addr 0 return 0, rd_busy=0.
REQ-021 Scoreboard: reserve addr 7 -> rd_busy=1 the next cycle. Write addr 7 -> rd_busy=0 in the write cycle via bypass and after the edge. Reserve and write addr 9 in the same cycle -> busy stays 1.
REQ-022 Clear: preload entries 1..31 = index value, pulse clr_req -> ready low for exactly 32 cycles; entry k reads 0 after cycle k; writes issued mid-clear are lost; ready=1 afterwards.
REQ-023 Async reset: assert rst_n=0 between clock edges during CLEAR -> ready=1 and all reads return 0 immediately, without waiting for clk.
